temporal_encoder: RTL and testbench
===================================

Name: temporal_encoder

Overview:
- Upstream feeder for the race-logic comparison stage (not_equal).
- Takes one pair of binary operands per transaction and produces that stage's `set`, `a` and `b` stimulus as temporal events on the `aclk` grid. A value v becomes an edge (or a pulse width) v cycles after the window origin.
- Supports rising-edge, falling-edge and pulse-width encodings, selected per transaction.

Parameters:
- WIDTH, 4: operand width in bits.
- GAMMA, 16: window length in cycles. Must satisfy 2 <= GAMMA <= 2**WIDTH.
- CW, $clog2(GAMMA): width of the internal time counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- grst  in  1  reset; synchronous, active-high.
- in_valid  in  1  transaction request.
- in_ready  out  1  block can accept a transaction; high only in IDLE.
- in_a  in  WIDTH  operand for channel a.
- in_b  in  WIDTH  operand for channel b.
- in_null_a  in  1  channel a carries "infinity" (no event).
- in_null_b  in  1  channel b carries "infinity" (no event).
- in_mode  in  2  encoding: 00 = rising, 01 = falling, 10 = pulse width, 11 = reserved (treated as rising).
- set  out  1  one-cycle initialisation strobe to the downstream stage.
- a  out  1  temporal output, channel a.
- b  out  1  temporal output, channel b.
- busy  out  1  high in SET, RUN and DONE.
- done  out  1  one-cycle strobe at the end of the window.

Behaviour:
- Reset (grst=1 at a clock edge):
  - state <= IDLE; counter t <= 0.
  - set, a, b, done <= 0.
  - Latched operands and mode cleared to 0.
  - Reset aborts any operation in flight; no done is issued for it.
- All outputs are registered. in_ready = (state==IDLE) and is low while grst=1.
- States:
  - IDLE: outputs hold their last values. If in_valid && in_ready at edge k:
    - latch in_a, in_b, null flags and mode;
    - go to SET.
  - SET (cycle k+1):
    - set=1;
    - a and b driven to baseline: 1 for falling, 0 for rising and pulse;
    - t <= 0; go to RUN.
  - RUN (cycles k+2 .. k+1+GAMMA): t counts 0..GAMMA-1; set=0. Per channel, with latched value v and null flag n:
    - rising: output = (!n && t >= v).
    - falling: output = !(!n && t >= v).
    - pulse: output = (!n && t < v). v=0 gives no pulse.
    - Effective null: v >= GAMMA is treated as n=1 (saturates to infinity).
    - Outputs are computed from the next t value so the edge appears exactly at cycle k+2+v.
    - At t==GAMMA-1, go to DONE.
  - DONE (cycle k+2+GAMMA): done=1; a and b hold; go to IDLE.
- in_ready returns at cycle k+3+GAMMA.
- Back-to-back transactions: one every GAMMA+3 cycles.
- in_valid while not in IDLE is ignored; the request is not queued.
- Simultaneous events: channels are independent. a == b produces coincident edges in the same cycle.
- Counter t never wraps; it is frozen outside RUN.

Decomposition:
- Package temporal_pkg:
  - enum enc_mode_t {ENC_RISE, ENC_FALL, ENC_PW, ENC_RSVD};
  - enum enc_state_t {IDLE, SET, RUN, DONE}.
  - Shared by the encoder and later stages.
- Sub-module temporal_edge_gen, instantiated twice (a and b):
  - inputs: aclk, grst, start (SET cycle), t_next, value, null, mode;
  - output: one registered temporal bit.
- The top module contains the FSM, the counter and the handshake only.

Test Plan (WIDTH=4, GAMMA=16):
- Rising, in_a=3, in_b=7, accepted at edge k:
  - set=1 at k+1;
  - a rises at k+5, b rises at k+9, both stay high;
  - done at k+18; in_ready at k+19.
- Falling, in_a=in_b=0: both fall at k+2 (coincident); set baseline is a=b=1 at k+1.
- Pulse, in_a=5, in_b=0: a high for cycles k+2..k+6 (exactly 5 cycles); b never high.
- Nulls, rising, in_null_a=1, in_b=15, separately in_a=... : a stays 0 through done; b rises at k+17.
- Busy handling and mid-window reset:
  - in_valid held during RUN: no second set until IDLE; the next accept is at the earliest k+19.
  - grst asserted at k+6: all outputs 0 and in_ready=0 during grst, then in_ready=1 the cycle after grst deasserts; no done strobe.

Source files
------------

// File: rtl/temporal_pkg.sv
// Shared types for the race-logic front end: encoding modes and the encoder FSM states.
package temporal_pkg;

    typedef enum logic [1:0] {
        ENC_RISE = 2'b00,
        ENC_FALL = 2'b01,
        ENC_PW   = 2'b10,
        ENC_RSVD = 2'b11
    } enc_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SET,
        RUN,
        DONE
    } enc_state_t;

    // Level a channel sits at before its event: only falling-edge encoding idles high.
    function automatic logic enc_baseline(input enc_mode_t mode);
        return (mode == ENC_FALL);
    endfunction

endpackage

// File: rtl/temporal_edge_gen.sv
// One temporal channel: turns a latched value into an edge or pulse on the time grid.
module temporal_edge_gen
    import temporal_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAMMA = 16,
    parameter int CW    = $clog2(GAMMA)
) (
    input  logic             aclk,
    input  logic             grst,
    input  logic             start_i,
    input  logic             run_i,
    input  logic [CW-1:0]    t_next_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             null_i,
    input  enc_mode_t        mode_i,
    output logic             out_o
);

    logic out_q, out_d;
    logic eff_null;
    logic reached;
    logic in_pulse;

    // Values at or beyond the window length can never fire, so they saturate to "no event".
    always_comb begin
        eff_null = null_i || (32'(value_i) >= 32'(GAMMA));
        reached  = !eff_null && (32'(t_next_i) >= 32'(value_i));
        in_pulse = !eff_null && (32'(t_next_i) <  32'(value_i));
        out_d    = out_q;
        if (start_i) begin
            out_d = enc_baseline(mode_i);
        end else if (run_i) begin
            case (mode_i)
                ENC_FALL: out_d = !reached;
                ENC_PW:   out_d = in_pulse;
                default:  out_d = reached;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/temporal_encoder.sv
// Converts a pair of binary operands into set/a/b temporal stimulus for the comparison stage.
module temporal_encoder
    import temporal_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAMMA = 16,
    parameter int CW    = $clog2(GAMMA)
) (
    input  logic             aclk,
    input  logic             grst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_null_a,
    input  logic             in_null_b,
    input  logic [1:0]       in_mode,
    output logic             set,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0] T_LAST = CW'(GAMMA - 1);

    enc_state_t       state_q, state_d;
    logic [CW-1:0]    t_q, t_d;
    enc_mode_t        mode_q, mode_d;
    logic [WIDTH-1:0] val_q [2];
    logic [WIDTH-1:0] val_d [2];
    logic             null_q [2];
    logic             null_d [2];
    logic [WIDTH-1:0] in_val [2];
    logic             in_null [2];
    logic             set_q, done_q;
    logic             accept;
    logic             start_ch, run_ch;
    logic [1:0]       ch_out;

    assign in_val[0]  = in_a;
    assign in_val[1]  = in_b;
    assign in_null[0] = in_null_a;
    assign in_null[1] = in_null_b;

    assign in_ready = (state_q == IDLE) && !grst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        mode_d  = mode_q;
        for (int i = 0; i < 2; i++) begin
            val_d[i]  = val_q[i];
            null_d[i] = null_q[i];
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SET;
                    mode_d  = enc_mode_t'(in_mode);
                    for (int i = 0; i < 2; i++) begin
                        val_d[i]  = in_val[i];
                        null_d[i] = in_null[i];
                    end
                end
            end
            SET: begin
                state_d = RUN;
                t_d     = '0;
            end
            RUN: begin
                // Counter stops at the last slot instead of wrapping.
                if (t_q == T_LAST) begin
                    state_d = DONE;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q <= IDLE;
            t_q     <= '0;
            mode_q  <= ENC_RISE;
            set_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                val_q[i]  <= '0;
                null_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            mode_q  <= mode_d;
            set_q   <= (state_d == SET);
            done_q  <= (state_d == DONE);
            for (int i = 0; i < 2; i++) begin
                val_q[i]  <= val_d[i];
                null_q[i] <= null_d[i];
            end
        end
    end

    // Channels see next-state values so each registered output lines up with its state and t.
    assign start_ch = (state_d == SET);
    assign run_ch   = (state_d == RUN);

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        temporal_edge_gen #(
            .WIDTH (WIDTH),
            .GAMMA (GAMMA),
            .CW    (CW)
        ) u_edge (
            .aclk     (aclk),
            .grst     (grst),
            .start_i  (start_ch),
            .run_i    (run_ch),
            .t_next_i (t_d),
            .value_i  (val_d[gi]),
            .null_i   (null_d[gi]),
            .mode_i   (mode_d),
            .out_o    (ch_out[gi])
        );
    end

    assign set  = set_q;
    assign done = done_q;
    assign a    = ch_out[0];
    assign b    = ch_out[1];
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder (WIDTH=4, GAMMA=16); trace bit m = value seen at edge k+m.
module tb_temporal_encoder;

    logic       aclk = 1'b0;
    logic       grst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_null_a;
    logic       in_null_b;
    logic [1:0] in_mode;
    logic       set;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [20:0] set_tr, a_tr, b_tr, done_tr, busy_tr, rdy_tr;

    temporal_encoder #(
        .WIDTH (4),
        .GAMMA (16)
    ) dut (
        .aclk      (aclk),
        .grst      (grst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_null_a (in_null_a),
        .in_null_b (in_null_b),
        .in_mode   (in_mode),
        .set       (set),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the encoder idle; the next posedge is the accept edge k.
    task automatic run_txn(input logic [1:0] mode, input logic [3:0] va, input logic [3:0] vb,
                           input logic na, input logic nb, input logic hold);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_a      = va;
        in_b      = vb;
        in_null_a = na;
        in_null_b = nb;
        @(posedge aclk);
        set_tr = '0; a_tr = '0; b_tr = '0; done_tr = '0; busy_tr = '0; rdy_tr = '0;
        for (int m = 1; m <= 20; m++) begin
            @(negedge aclk);
            set_tr[m]  = set;
            a_tr[m]    = a;
            b_tr[m]    = b;
            done_tr[m] = done;
            busy_tr[m] = busy;
            rdy_tr[m]  = in_ready;
            if (!hold) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        $display("[TB] txn mode=%0d a=%0d b=%0d na=%0b nb=%0b set=%h a=%h b=%h done=%h",
                 mode, va, vb, na, nb, set_tr, a_tr, b_tr, done_tr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        int   waited;
        grst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_null_a = 1'b0; in_null_b = 1'b0; in_mode = 2'b00;
        repeat (3) @(negedge aclk);
        chk("reset_outputs", {27'd0, set, a, b, done, busy}, 32'h0);
        chk("reset_ready_low", {31'd0, in_ready}, 32'h0);
        grst = 1'b0;
        #1;
        chk("reset_ready_high", {31'd0, in_ready}, 32'h1);
        @(negedge aclk);

        // Rising 3/7: a at k+5, b at k+9, done k+18, in_ready k+19.
        run_txn(2'b00, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0);
        chk("rise_set",  set_tr,  32'h000002);
        chk("rise_a",    a_tr,    32'h1FFFE0);
        chk("rise_b",    b_tr,    32'h1FFE00);
        chk("rise_done", done_tr, 32'h040000);
        chk("rise_busy", busy_tr, 32'h07FFFE);
        chk("rise_rdy",  rdy_tr,  32'h180000);

        // Falling 0/0: baseline high at k+1, both fall together at k+2.
        run_txn(2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("fall0_set", set_tr, 32'h000002);
        chk("fall0_a",   a_tr,   32'h000002);
        chk("fall0_b",   b_tr,   32'h000002);

        // Pulse 5/0: a high k+2..k+6, b never.
        run_txn(2'b10, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("pw_a", a_tr, 32'h00007C);
        chk("pw_b", b_tr, 32'h000000);

        // Rising with null a, b=15 at the last slot.
        run_txn(2'b00, 4'd9, 4'd15, 1'b1, 1'b0, 1'b0);
        chk("null_a",    a_tr,    32'h000000);
        chk("null_b",    b_tr,    32'h1E0000);
        chk("null_done", done_tr, 32'h040000);

        // Falling 15 with null b: a falls at k+17, b stays high.
        run_txn(2'b01, 4'd15, 4'd2, 1'b0, 1'b1, 1'b0);
        chk("fall15_a", a_tr, 32'h01FFFE);
        chk("fall15_b", b_tr, 32'h1FFFFE);

        // Reserved mode behaves as rising.
        run_txn(2'b11, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("rsvd_a", a_tr, 32'h1FFFF0);
        chk("rsvd_b", b_tr, 32'h1FFFC0);

        // Pulse with null a, b=15: b high k+2..k+16.
        run_txn(2'b10, 4'd7, 4'd15, 1'b1, 1'b0, 1'b0);
        chk("pwnull_a", a_tr, 32'h000000);
        chk("pwnull_b", b_tr, 32'h01FFFC);

        // in_valid held throughout: second accept only at k+19, set again at k+20.
        run_txn(2'b00, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1);
        chk("held_set",  set_tr,  32'h100002);
        chk("held_a",    a_tr,    32'h0FFFE0);
        chk("held_b",    b_tr,    32'h0FFE00);
        chk("held_done", done_tr, 32'h040000);
        chk("held_busy", busy_tr, 32'h17FFFE);
        chk("held_rdy",  rdy_tr,  32'h080000);
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge aclk);
            waited++;
        end
        chk("drain_idle", {31'd0, in_ready}, 32'h1);

        // Mid-window reset sampled at edge k+6.
        in_valid = 1'b1; in_mode = 2'b00; in_a = 4'd3; in_b = 4'd7;
        in_null_a = 1'b0; in_null_b = 1'b0;
        @(posedge aclk);
        for (int m = 1; m <= 6; m++) begin
            @(negedge aclk);
            in_valid = 1'b0;
        end
        chk("prerst_a", {31'd0, a}, 32'h1);
        grst = 1'b1;
        @(negedge aclk);
        chk("midrst_outputs", {27'd0, set, a, b, done, busy}, 32'h0);
        chk("midrst_ready_low", {31'd0, in_ready}, 32'h0);
        grst = 1'b0;
        #1;
        chk("midrst_ready_high", {31'd0, in_ready}, 32'h1);
        seen = 1'b0;
        for (int m = 0; m < 25; m++) begin
            @(negedge aclk);
            seen = seen | done | set | busy;
        end
        chk("midrst_no_done", {31'd0, seen}, 32'h0);
        $display("[TB] mid-window reset sequence complete");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
